// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access unit: request op codes, FSM
// state encoding and the request legality check.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RMW  = 3'd2,
    ST_WR   = 3'd3,
    ST_ERR  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  // Unsigned-extend ops exist only for loads; a store using them is rejected.
  function automatic logic req_error(input logic        write,
                                     input logic [2:0]  op,
                                     input logic [31:0] addr,
                                     input logic [31:0] mem_bytes);
    logic bad;
    case (op)
      OP_B:    bad = 1'b0;
      OP_BU:   bad = write;
      OP_H:    bad = addr[0];
      OP_HU:   bad = write | addr[0];
      OP_W:    bad = |addr[1:0];
      default: bad = 1'b1;
    endcase
    return bad | (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane logic: extracts and extends sub-word loads, and merges a
// byte/halfword store into an existing word leaving the other lanes untouched.
module byte_lane_merge
  import mem_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (op_i)
      OP_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      OP_BU:   load_o = {24'h0, byte_sel};
      OP_H:    load_o = {{16{half_sel[15]}}, half_sel};
      OP_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (op_i)
      OP_B, OP_BU: merge_o[{lane_i, 3'b000} +: 8] = store_i[7:0];
      OP_H, OP_HU: begin
        if (lane_i[1]) merge_o[31:16] = store_i[15:0];
        else           merge_o[15:0]  = store_i[15:0];
      end
      default: merge_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side initiator for a word-addressed data memory with combinational read
// and posedge write. One request in flight; sub-word stores use read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  // Request handshake: a request is taken on a posedge where reqValid and
  // reqReady are both high; reqReady is high only in IDLE and there is no queue.
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqOp,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqData,
  output logic        respValid,
  output logic        respError,
  output logic [31:0] loadData,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  output logic        memRead,
  output logic        memWrite,
  output logic [2:0]  dbgState
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_e      state_q;
  logic        write_q;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] merge_q;
  logic [31:0] load_q;

  logic        req_bad;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  assign req_bad = req_error(reqWrite, reqOp, reqAddr, MEM_LIMIT);

  byte_lane_merge u_lane (
    .op_i    (op_q),
    .lane_i  (addr_q[1:0]),
    .word_i  (memReadData),
    .store_i (data_q),
    .load_o  (lane_load),
    .merge_o (lane_merge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
      merge_q <= 32'h0;
      load_q  <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid) begin
            write_q <= reqWrite;
            op_q    <= reqOp;
            addr_q  <= reqAddr;
            data_q  <= reqData;
            if (req_bad)           state_q <= ST_ERR;
            else if (!reqWrite)    state_q <= ST_LOAD;
            else if (reqOp == OP_W) state_q <= ST_WR;
            else                   state_q <= ST_RMW;
          end
        end
        ST_LOAD: begin
          load_q  <= lane_load;
          state_q <= ST_DONE;
        end
        ST_RMW: begin
          merge_q <= lane_merge;
          state_q <= ST_WR;
        end
        ST_WR:   state_q <= ST_DONE;
        ST_ERR:  state_q <= ST_IDLE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from the state register so an async
  // reset drops memWrite immediately.
  always_comb begin
    reqReady     = (state_q == ST_IDLE);
    respValid    = (state_q == ST_DONE) || (state_q == ST_ERR);
    respError    = (state_q == ST_ERR);
    memRead      = (state_q == ST_LOAD) || (state_q == ST_RMW);
    memWrite     = (state_q == ST_WR);
    memAddress   = (memRead || memWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
    memWriteData = 32'h0;
    if (memWrite) memWriteData = (op_q == OP_W) ? data_q : merge_q;
    loadData     = load_q;
    dbgState     = state_q;
  end

  // write_q is kept for debug visibility of the accepted request.
  logic unused_ok;
  assign unused_ok = write_q;

endmodule
